t10_tick_gen: RTL
=================

Name: t10_tick_gen

Overview:
- Multi-channel programmable tick generator. Successor to the single-counter clock divider.
- One shared prescaler drives N independent channel counters. Each channel has its own period, a periodic or one-shot mode, start/stop control and a shadowed period reload.
- Feeds timing strobes to team_10 peripherals such as debounce, PWM base and display refresh.

Parameters:
- NCH, 4, number of channels (1..8)
- W, 17, channel period/count width
- PW, 8, prescaler width

Ports:
- clk  in  1  system clock
- nRst  in  1  reset, asynchronous, active-low
- prescale_max  in  PW  prescaler terminal value; one step every prescale_max+1 cycles
- cfg_we  in  1  write strobe for channel period/mode
- cfg_ch  in  $clog2(NCH) (min 1)  channel addressed by cfg_we
- cfg_period  in  W  new period; channel wraps at this count
- cfg_mode  in  1  0=PERIODIC, 1=ONESHOT
- start  in  NCH  per-channel start pulse
- stop  in  NCH  per-channel stop pulse
- tick  out  NCH  one-cycle registered pulse at wrap
- running  out  NCH  channel counting
- done  out  NCH  sticky; set when a one-shot completes

Behaviour:
- Reset: all count, shadow_period, active_period, mode, prescaler = 0; tick, running, done = 0.
- Prescaler:
  - pre_cnt counts 0..prescale_max. step = running_any & (pre_cnt == prescale_max). At step, pre_cnt -> 0.
  - pre_cnt is held at 0 while no channel runs.
  - prescale_max = 0 -> step every cycle while running.
  - prescale_max changed mid-count: compare uses the new value; if pre_cnt > new max, pre_cnt counts up and wraps at 2^PW (no clamp).
- Config write (cfg_we):
  - Writes shadow_period[cfg_ch] and mode[cfg_ch].
  - Channel idle: active_period is also loaded on the same edge.
  - Channel running: active_period loads from shadow at the next wrap only. Mode takes effect immediately.
  - cfg_ch >= NCH: write ignored.
- Start (start[i], channel not stopping):
  - count <= 0, running <= 1, done <= 0, active_period <= shadow_period (including a same-cycle cfg write to that channel).
  - Start while running restarts the channel from 0.
- Step while running[i]:
  - count != active_period: count + 1.
  - count == active_period: count <= 0, tick[i] <= 1 (high the next cycle, exactly one cycle), active_period <= shadow_period.
  - ONESHOT additionally: running <= 0, done <= 1.
- Period P -> tick every (P+1)*(prescale_max+1) cycles. P=0 and prescale_max=0 -> tick every cycle.
- First tick after start with prescale_max=0: start edge at cycle 0, tick high in cycle P+1.
- Stop (stop[i]): running <= 0, count <= 0, no tick, done unchanged.
- start and stop in the same cycle: stop wins.
- Stop coincident with a wrap step: no tick.
- Count never exceeds active_period. Wrap at the all-ones period is valid, with no overflow past W bits.
- Reset mid-operation: everything returns to reset values asynchronously; tick deasserts immediately.

Decomposition:
- Package t10_tick_pkg:
  - typedef enum logic {TICK_PERIODIC, TICK_ONESHOT} tick_mode_t
  - localparam default widths
- Sub-module t10_tick_channel: one channel's count, shadow/active period, mode, running/done/tick registers. Inputs: step, start, stop, cfg_we_i, cfg_period, cfg_mode.
- Top level: prescaler, cfg_ch decode, generate loop over NCH channels.

Test Plan:
- Reset: assert nRst low mid-count -> tick/running/done = 0 immediately. After release, no tick until a start.
- Periodic: prescale_max=0, ch0 period=3, start[0] at cycle 0 -> tick[0] high in cycles 4, 8, 12, each exactly one cycle wide.
- Prescale plus one-shot: prescale_max=2, ch1 ONESHOT period=1, start[1] -> single tick after 6 cycles, then running[1]=0 and done[1]=1. A later start[1] clears done[1].
- Shadow reload: ch2 period=4 running; write period=1 at count=2 -> next wrap after period 4 as before, then ticks every 2 cycles.
- Simultaneous: start[3] and stop[3] in the same cycle -> running[3] stays 0. stop[0] on a wrap step -> no tick[0].
- Independence and edge values: period=0 on ch0 -> tick every cycle; period=2^W-1 on ch1 wraps cleanly. A cfg write with cfg_ch=NCH changes nothing.

Source files
------------

// File: rtl/t10_tick_pkg.sv
// Shared types and default widths for the multi-channel tick generator.
package t10_tick_pkg;

  typedef enum logic {
    TICK_PERIODIC = 1'b0,
    TICK_ONESHOT  = 1'b1
  } tick_mode_t;

  localparam int unsigned TICK_NCH = 4;
  localparam int unsigned TICK_W   = 17;
  localparam int unsigned TICK_PW  = 8;

endpackage

// File: rtl/t10_tick_channel.sv
// One tick channel: counter with shadowed period reload, periodic/one-shot mode,
// start/stop control and a registered one-cycle tick at each wrap.
module t10_tick_channel
  import t10_tick_pkg::*;
#(
  parameter int unsigned W = TICK_W
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic         step,
  input  logic         start,
  input  logic         stop,
  input  logic         cfg_we_i,
  input  logic [W-1:0] cfg_period,
  input  tick_mode_t   cfg_mode,
  output logic         tick,
  output logic         running,
  output logic         done
);

  logic [W-1:0] count;
  logic [W-1:0] shadow_period;
  logic [W-1:0] active_period;
  tick_mode_t   mode;

  // NOTE: all state uses non-blocking assignments, so later assignments in this
  // block override earlier ones cleanly and every read sees pre-edge values.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      count         <= '0;
      shadow_period <= '0;
      active_period <= '0;
      mode          <= TICK_PERIODIC;
      tick          <= 1'b0;
      running       <= 1'b0;
      done          <= 1'b0;
    end else begin
      tick <= 1'b0;

      // An idle channel takes the new period at once; a running one waits for its wrap.
      if (cfg_we_i) begin
        shadow_period <= cfg_period;
        mode          <= cfg_mode;
        if (!running) active_period <= cfg_period;
      end

      if (stop) begin
        running <= 1'b0;
        count   <= '0;
      end else if (start) begin
        count         <= '0;
        running       <= 1'b1;
        done          <= 1'b0;
        active_period <= cfg_we_i ? cfg_period : shadow_period;
      end else if (running && step) begin
        if (count == active_period) begin
          count         <= '0;
          tick          <= 1'b1;
          active_period <= shadow_period;
          if (mode == TICK_ONESHOT) begin
            running <= 1'b0;
            done    <= 1'b1;
          end
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/t10_tick_gen.sv
// Multi-channel tick generator: one shared prescaler stepping NCH independent
// channel counters, with per-channel configuration addressed by cfg_ch.
module t10_tick_gen
  import t10_tick_pkg::*;
#(
  parameter  int unsigned NCH = TICK_NCH,
  parameter  int unsigned W   = TICK_W,
  parameter  int unsigned PW  = TICK_PW,
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           nRst,
  input  logic [PW-1:0]  prescale_max,
  input  logic           cfg_we,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [W-1:0]   cfg_period,
  input  logic           cfg_mode,
  input  logic [NCH-1:0] start,
  input  logic [NCH-1:0] stop,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] running,
  output logic [NCH-1:0] done
);

  logic [PW-1:0] pre_cnt;
  logic          running_any;
  logic          step;

  assign running_any = |running;
  assign step        = running_any && (pre_cnt == prescale_max);

  // Lowering prescale_max below pre_cnt lets the counter run on and wrap at 2^PW.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      pre_cnt <= '0;
    end else if (!running_any || step) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic ch_we;

    // Out-of-range cfg_ch values match no channel, so such writes are dropped.
    assign ch_we = cfg_we && (cfg_ch == CW'(i));

    t10_tick_channel #(.W(W)) u_ch (
      .clk        (clk),
      .nRst       (nRst),
      .step       (step),
      .start      (start[i]),
      .stop       (stop[i]),
      .cfg_we_i   (ch_we),
      .cfg_period (cfg_period),
      .cfg_mode   (tick_mode_t'(cfg_mode)),
      .tick       (tick[i]),
      .running    (running[i]),
      .done       (done[i])
    );
  end

endmodule
